apb_bridge_arbiter: RTL and testbench

- Two-requester APB master that time-shares the peripheral APB bus between the UART and GPIO slaves.
- Arbitrates between requester 0 and requester 1 with round-robin priority.
- Decodes the target slave, runs a standard SETUP/ACCESS transfer and waits on that slave's PREADY with a timeout.
- Returns read data and completion/error status to the winning requester.

---
 rtl/apb_bridge_arbiter.sv | 161 ++++++++++++++++
 tb/tb_apb_bridge_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_arbiter.sv
// Two-requester APB master: round-robin arbitration, UART/GPIO decode,
// SETUP/ACCESS sequencing with a PREADY timeout, per-requester completion.
module apb_bridge_arbiter #(
   parameter int TIMEOUT      = 16,
   parameter int GPIO_SEL_BIT = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req0_wr,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   input  logic [3:0]  req0_strb,
   output logic        req0_done,
   output logic        req0_err,
   output logic [31:0] req0_rdata,
   input  logic        req1,
   input  logic        req1_wr,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   input  logic [3:0]  req1_strb,
   output logic        req1_done,
   output logic        req1_err,
   output logic [31:0] req1_rdata,
   output logic [31:0] padd,
   output logic [31:0] pdata,
   output logic [3:0]  PSTRB,
   output logic        pwr,
   output logic        pen,
   output logic        psel_uart,
   output logic        psel_gpio,
   input  logic [31:0] prdata_uart,
   input  logic [31:0] prdata_gpio,
   input  logic        PREADY_uart,
   input  logic        PREADY_gpio
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t      state;
   state_t      next_state;
   logic        grant;
   logic        last_grant;
   logic        sel_gpio;
   logic        err_q;
   logic [7:0]  cnt;
   logic [31:0] rdata0;
   logic [31:0] rdata1;

   logic        any_req;
   logic        win;
   logic        cur_wr;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [3:0]  cur_strb;
   logic        dec_err;
   logic        ready;
   logic        timeout_hit;

   // With both requesters asserted the one that did not win last time goes next.
   assign any_req     = req0 | req1;
   assign win         = (req0 && req1) ? ~last_grant : req1;
   assign cur_wr      = win ? req1_wr    : req0_wr;
   assign cur_addr    = win ? req1_addr  : req0_addr;
   assign cur_wdata   = win ? req1_wdata : req0_wdata;
   assign cur_strb    = win ? req1_strb  : req0_strb;
   assign dec_err     = |cur_addr[31:13];
   assign ready       = sel_gpio ? PREADY_gpio : PREADY_uart;
   assign timeout_hit = (cnt == 8'(TIMEOUT - 1));
   assign req0_rdata  = rdata0;
   assign req1_rdata  = rdata1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_req) next_state = dec_err ? RESP : SETUP;
         SETUP:   next_state = ACCESS;
         ACCESS:  if (ready || timeout_hit) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      psel_uart = 1'b0;
      psel_gpio = 1'b0;
      pen       = 1'b0;
      req0_done = 1'b0;
      req1_done = 1'b0;
      if (state == SETUP || state == ACCESS) begin
         psel_uart = ~sel_gpio;
         psel_gpio = sel_gpio;
      end
      if (state == ACCESS) pen = 1'b1;
      if (state == RESP) begin
         req0_done = ~grant;
         req1_done = grant;
      end
      req0_err = req0_done & err_q;
      req1_err = req1_done & err_q;
   end

   // Bus fields are loaded only on a decodable grant, so a decode error
   // leaves the previous transfer's values on padd/pdata/PSTRB/pwr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant      <= 1'b0;
         last_grant <= 1'b1;
         sel_gpio   <= 1'b0;
         err_q      <= 1'b0;
         cnt        <= 8'd0;
         padd       <= 32'd0;
         pdata      <= 32'd0;
         PSTRB      <= 4'd0;
         pwr        <= 1'b0;
         rdata0     <= 32'd0;
         rdata1     <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant      <= win;
                  last_grant <= win;
                  err_q      <= dec_err;
                  if (!dec_err) begin
                     sel_gpio <= cur_addr[GPIO_SEL_BIT];
                     padd     <= {20'd0, cur_addr[11:0]};
                     pdata    <= cur_wdata;
                     PSTRB    <= cur_wr ? cur_strb : 4'd0;
                     pwr      <= cur_wr;
                  end
               end
            end
            SETUP: cnt <= 8'd0;
            ACCESS: begin
               if (ready) begin
                  err_q <= 1'b0;
                  if (!pwr) begin
                     if (grant) rdata1 <= sel_gpio ? prdata_gpio : prdata_uart;
                     else       rdata0 <= sel_gpio ? prdata_gpio : prdata_uart;
                  end
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Randomized bench: a transaction-level model predicts winner, bus fields,
// completion cycle, error and read data, and checks every cycle.
module tb_apb_bridge_arbiter;

   localparam int TO       = 4;
   localparam int GPIO_BIT = 12;

   logic        clk;
   logic        rst;
   logic        req0, req0_wr, req0_done, req0_err;
   logic [31:0] req0_addr, req0_wdata, req0_rdata;
   logic [3:0]  req0_strb;
   logic        req1, req1_wr, req1_done, req1_err;
   logic [31:0] req1_addr, req1_wdata, req1_rdata;
   logic [3:0]  req1_strb;
   logic [31:0] padd, pdata, prdata_uart, prdata_gpio;
   logic [3:0]  PSTRB;
   logic        pwr, pen, psel_uart, psel_gpio, PREADY_uart, PREADY_gpio;

   apb_bridge_arbiter #(.TIMEOUT(TO), .GPIO_SEL_BIT(GPIO_BIT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_strb(req0_strb), .req0_done(req0_done), .req0_err(req0_err), .req0_rdata(req0_rdata),
      .req1(req1), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_strb(req1_strb), .req1_done(req1_done), .req1_err(req1_err), .req1_rdata(req1_rdata),
      .padd(padd), .pdata(pdata), .PSTRB(PSTRB), .pwr(pwr), .pen(pen),
      .psel_uart(psel_uart), .psel_gpio(psel_gpio),
      .prdata_uart(prdata_uart), .prdata_gpio(prdata_gpio),
      .PREADY_uart(PREADY_uart), .PREADY_gpio(PREADY_gpio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checkCount = 0;
   int          errorCount = 0;
   logic        act     [2];
   logic        wr_m    [2];
   logic [31:0] addr_m  [2];
   logic [31:0] wdata_m [2];
   logic [3:0]  strb_m  [2];
   logic [31:0] rdata_m [2];
   int          lastGrant;
   logic [31:0] expPadd, expPdata;
   logic [3:0]  expStrb;
   logic        expPwr;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkBus(input logic eUart, input logic eGpio, input logic ePen,
                           input logic eDone0, input logic eErr0, input logic eDone1, input logic eErr1);
      checkOutput("psel_uart", 32'(psel_uart), 32'(eUart));
      checkOutput("psel_gpio", 32'(psel_gpio), 32'(eGpio));
      checkOutput("pen", 32'(pen), 32'(ePen));
      checkOutput("padd", padd, expPadd);
      checkOutput("pdata", pdata, expPdata);
      checkOutput("PSTRB", 32'(PSTRB), 32'(expStrb));
      checkOutput("pwr", 32'(pwr), 32'(expPwr));
      checkOutput("req0_done", 32'(req0_done), 32'(eDone0));
      checkOutput("req0_err", 32'(req0_err), 32'(eErr0));
      checkOutput("req0_rdata", req0_rdata, rdata_m[0]);
      checkOutput("req1_done", 32'(req1_done), 32'(eDone1));
      checkOutput("req1_err", 32'(req1_err), 32'(eErr1));
      checkOutput("req1_rdata", req1_rdata, rdata_m[1]);
   endtask

   task automatic driveInputs();
      req0 = act[0]; req0_wr = wr_m[0]; req0_addr = addr_m[0]; req0_wdata = wdata_m[0]; req0_strb = strb_m[0];
      req1 = act[1]; req1_wr = wr_m[1]; req1_addr = addr_m[1]; req1_wdata = wdata_m[1]; req1_strb = strb_m[1];
   endtask

   task automatic randomSlaves();
      PREADY_uart = 1'($urandom_range(0, 1));
      PREADY_gpio = 1'($urandom_range(0, 1));
      prdata_uart = $urandom;
      prdata_gpio = $urandom;
   endtask

   task automatic newRequest(input int r);
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[31:13] = '0;
      else if (a[31:13] == '0) a[31] = 1'b1;
      act[r] = 1'b1; wr_m[r] = 1'($urandom_range(0, 1)); addr_m[r] = a;
      wdata_m[r] = $urandom; strb_m[r] = 4'($urandom);
   endtask

   task automatic newRequests();
      for (int r = 0; r < 2; r++) if (!act[r] && $urandom_range(0, 1) == 1) newRequest(r);
      if (!act[0] && !act[1]) newRequest(int'($urandom_range(0, 1)));
   endtask

   // Changes to the winner's fields mid-transfer must not reach the bus.
   task automatic scrambleInputs(input int w);
      if (w == 0) begin
         req0_wr = ~req0_wr; req0_addr = $urandom; req0_wdata = $urandom; req0_strb = 4'($urandom);
      end else begin
         req1_wr = ~req1_wr; req1_addr = $urandom; req1_wdata = $urandom; req1_strb = 4'($urandom);
      end
   endtask

   // Entered at the falling edge of an idle cycle with requests already driven.
   task automatic applyStimulus();
      int          w, d;
      logic        dec, gpio, isWr, expErr;
      logic [31:0] a, readVal;
      w = (act[0] && act[1]) ? ((lastGrant == 0) ? 1 : 0) : (act[1] ? 1 : 0);
      lastGrant = w;
      a = addr_m[w];
      dec = |a[31:13];
      gpio = a[GPIO_BIT];
      isWr = wr_m[w];
      d = int'($urandom_range(0, 5));
      expErr = 1'b1;
      readVal = rdata_m[w];
      if (!dec) begin
         @(negedge clk);
         expPadd = {20'd0, a[11:0]}; expPdata = wdata_m[w];
         expStrb = isWr ? strb_m[w] : 4'd0; expPwr = isWr;
         checkBus(!gpio, gpio, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         scrambleInputs(w);
         randomSlaves();
         for (int j = 0; j < TO; j++) begin
            @(negedge clk);
            checkBus(!gpio, gpio, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            randomSlaves();
            if (gpio) PREADY_gpio = (j == d);
            else      PREADY_uart = (j == d);
            if (j == d) begin
               expErr = 1'b0;
               if (!isWr) readVal = gpio ? prdata_gpio : prdata_uart;
               break;
            end
         end
      end
      @(negedge clk);
      rdata_m[w] = readVal;
      checkBus(1'b0, 1'b0, 1'b0, w == 0, (w == 0) && expErr, w == 1, (w == 1) && expErr);
      act[w] = 1'b0;
      driveInputs();
      randomSlaves();
      @(negedge clk);
      checkBus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      newRequests();
      driveInputs();
   endtask

   initial begin
      rst = 1'b0;
      for (int r = 0; r < 2; r++) begin
         act[r] = 1'b0; wr_m[r] = 1'b0; addr_m[r] = '0; wdata_m[r] = '0; strb_m[r] = '0; rdata_m[r] = '0;
      end
      lastGrant = 1;
      expPadd = '0; expPdata = '0; expStrb = '0; expPwr = 1'b0;
      driveInputs();
      randomSlaves();
      repeat (2) @(negedge clk);
      checkBus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      newRequests();
      driveInputs();
      for (int t = 0; t < 60; t++) applyStimulus();

      // Reset in the middle of an ACCESS phase that never completes.
      act[0] = 1'b1; act[1] = 1'b0; wr_m[0] = 1'b0; addr_m[0] = 32'h0000_0010;
      driveInputs();
      PREADY_uart = 1'b0; PREADY_gpio = 1'b0;
      @(negedge clk);
      expPadd = 32'h10; expPdata = wdata_m[0]; expStrb = 4'd0; expPwr = 1'b0;
      checkBus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkBus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      lastGrant = 1;
      expPadd = '0; expPdata = '0; expStrb = '0; expPwr = 1'b0;
      rdata_m[0] = '0; rdata_m[1] = '0;
      checkBus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkBus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      newRequest(0);
      newRequest(1);
      driveInputs();
      for (int t = 0; t < 4; t++) applyStimulus();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
